branch_predict_unit: RTL and testbench

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

---
 rtl/branch_predict_unit.sv | 124 ++++++++++++
 tb/tb_branch_predict_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Branch predictor: direct-mapped BHT/BTB with 2-bit counters, in-unit branch
// resolution, registered mispredict redirect and saturating performance counters.
module branch_predict_unit #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   lk_pc,
  output logic              lk_taken,
  output logic [XLEN-1:0]   lk_target,
  input  logic              res_valid,
  input  logic [XLEN-1:0]   res_pc,
  input  logic [XLEN-1:0]   res_s1,
  input  logic [XLEN-1:0]   res_s2,
  input  logic [XLEN-1:0]   res_imm,
  input  logic [2:0]        res_funct3,
  input  logic              res_pred_taken,
  input  logic [XLEN-1:0]   res_pred_target,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  mis_count
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  logic [1:0]       cnt_q [ENTRIES];
  logic [ENTRIES-1:0] vld_q;
  logic [TAG_W-1:0] tag_q [ENTRIES];
  logic [XLEN-1:0]  tgt_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] res_idx;
  logic [TAG_W-1:0] res_tag;
  logic             is_branch;
  logic             actual;
  logic             upd;
  logic             mispred;
  logic             res_hit;
  logic [1:0]       cnt_base;
  logic [1:0]       cnt_nxt;
  logic [XLEN-1:0]  res_tgt;
  logic [XLEN-1:0]  res_seq;
  logic             unused_ok;

  assign lk_idx  = lk_pc[IDX_W+1:2];
  assign lk_tag  = lk_pc[XLEN-1:IDX_W+2];
  assign res_idx = res_pc[IDX_W+1:2];
  assign res_tag = res_pc[XLEN-1:IDX_W+2];
  assign unused_ok = ^{lk_pc[1:0], res_pc[1:0]};

  // Lookup reads registered state only; same-cycle updates are not bypassed.
  assign lk_taken  = vld_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && cnt_q[lk_idx][1];
  assign lk_target = lk_taken ? tgt_q[lk_idx] : lk_pc + XLEN'(4);

  // Branch outcome; funct3 010/011 are not branches and are ignored.
  always_comb begin
    is_branch = 1'b1;
    actual    = 1'b0;
    case (res_funct3)
      3'b000:  actual = (res_s1 == res_s2);
      3'b001:  actual = (res_s1 != res_s2);
      3'b100:  actual = ($signed(res_s1) <  $signed(res_s2));
      3'b101:  actual = ($signed(res_s1) >= $signed(res_s2));
      3'b110:  actual = (res_s1 <  res_s2);
      3'b111:  actual = (res_s1 >= res_s2);
      default: is_branch = 1'b0;
    endcase
  end

  assign upd     = res_valid && is_branch;
  assign res_tgt = res_pc + res_imm;
  assign res_seq = res_pc + XLEN'(4);
  assign mispred = (actual != res_pred_taken) || (actual && (res_pred_target != res_tgt));
  assign res_hit = vld_q[res_idx] && (tag_q[res_idx] == res_tag);

  // Counter update: a tag miss restarts the entry at weakly-not-taken first.
  always_comb begin
    cnt_base = res_hit ? cnt_q[res_idx] : 2'b01;
    cnt_nxt  = cnt_base;
    if (actual) begin
      if (cnt_base != 2'b11) cnt_nxt = cnt_base + 2'd1;
    end else begin
      if (cnt_base != 2'b00) cnt_nxt = cnt_base - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) cnt_q[i] <= 2'b01;
    end else if (upd) begin
      cnt_q[res_idx] <= cnt_nxt;
      if (actual) vld_q[res_idx] <= 1'b1;
    end
  end

  // Tag and target carry no reset; they are only meaningful behind a valid bit.
  always_ff @(posedge clk) begin
    if (!rst && upd && actual) begin
      tag_q[res_idx] <= res_tag;
      tgt_q[res_idx] <= res_tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      br_count       <= '0;
      mis_count      <= '0;
    end else begin
      redirect_valid <= upd && mispred;
      if (upd && mispred) redirect_pc <= actual ? res_tgt : res_seq;
      if (upd && (br_count != '1)) br_count <= br_count + CNT_W'(1);
      if (upd && mispred && (mis_count != '1)) mis_count <= mis_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: stimulus pushes hand-computed
// expectations into a queue, a negedge monitor pops and compares them.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lk_pc;
  logic        lk_taken;
  logic [31:0] lk_target;
  logic        res_valid;
  logic [31:0] res_pc, res_s1, res_s2, res_imm;
  logic [2:0]  res_funct3;
  logic        res_pred_taken;
  logic [31:0] res_pred_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [15:0] br_count, mis_count;

  branch_predict_unit #(.XLEN(32), .ENTRIES(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .lk_pc(lk_pc), .lk_taken(lk_taken), .lk_target(lk_target),
    .res_valid(res_valid), .res_pc(res_pc), .res_s1(res_s1), .res_s2(res_s2),
    .res_imm(res_imm), .res_funct3(res_funct3), .res_pred_taken(res_pred_taken),
    .res_pred_target(res_pred_target), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .br_count(br_count), .mis_count(mis_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [2:0]  f3;
    logic [31:0] pc, s1, s2, imm;
    logic        pt;
    logic [31:0] ptg;
  } res_t;

  typedef struct {
    int unsigned cyc;
    int          kind;
    string       nm;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t mk(input logic v, input logic [2:0] f3, input logic [31:0] pc,
                              input logic [31:0] s1, input logic [31:0] s2,
                              input logic [31:0] imm, input logic pt, input logic [31:0] ptg);
    res_t r;
    r.v = v; r.f3 = f3; r.pc = pc; r.s1 = s1; r.s2 = s2; r.imm = imm; r.pt = pt; r.ptg = ptg;
    return r;
  endfunction

  // One cycle: drive inputs, queue this cycle's lookup check and next cycle's
  // redirect/counter checks.
  task automatic step(input string nm, input logic r, input logic [31:0] lpc,
                      input bit chk_lk, input logic etk, input logic [31:0] etg,
                      input res_t rs, input logic erv, input logic [31:0] erpc,
                      input int ebr, input int emis);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; lk_pc = lpc;
    res_valid = rs.v; res_funct3 = rs.f3; res_pc = rs.pc; res_s1 = rs.s1;
    res_s2 = rs.s2; res_imm = rs.imm; res_pred_taken = rs.pt; res_pred_target = rs.ptg;
    if (chk_lk) begin
      e.cyc = cyc; e.kind = 0; e.nm = {nm, "/lookup"}; e.a = {31'd0, etk}; e.b = etg;
      q.push_back(e);
    end
    e.cyc = cyc + 1; e.kind = 1; e.nm = {nm, "/redirect"}; e.a = {31'd0, erv}; e.b = erpc;
    q.push_back(e);
    e.cyc = cyc + 1; e.kind = 2; e.nm = {nm, "/counters"}; e.a = 32'(ebr); e.b = 32'(emis);
    q.push_back(e);
  endtask

  // Monitor: compare every expectation due in the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        case (e.kind)
          0: if (lk_taken !== e.a[0] || lk_target !== e.b) begin
               failures++;
               $display("FAIL %s: got taken=%0b target=%h, want taken=%0b target=%h",
                        e.nm, lk_taken, lk_target, e.a[0], e.b);
             end
          1: if (redirect_valid !== e.a[0] || (e.a[0] && redirect_pc !== e.b)) begin
               failures++;
               $display("FAIL %s: got valid=%0b pc=%h, want valid=%0b pc=%h",
                        e.nm, redirect_valid, redirect_pc, e.a[0], e.b);
             end
          default: if (br_count !== e.a[15:0] || mis_count !== e.b[15:0]) begin
               failures++;
               $display("FAIL %s: got br=%0d mis=%0d, want br=%0d mis=%0d",
                        e.nm, br_count, mis_count, e.a[15:0], e.b[15:0]);
             end
        endcase
      end
    end
  end

  initial begin
    res_t none;
    rst = 1'b1; lk_pc = '0; res_valid = 1'b0; res_pc = '0; res_s1 = '0; res_s2 = '0;
    res_imm = '0; res_funct3 = '0; res_pred_taken = 1'b0; res_pred_target = '0;
    none = mk(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);

    step("reset", 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, none, 1'b0, 32'h0, 0, 0);
    step("cold_train1", 1'b0, 32'h100, 1'b1, 1'b0, 32'h104,
         mk(1'b1, 3'b000, 32'h100, 32'd5, 32'd5, 32'h40, 1'b0, 32'h0), 1'b1, 32'h140, 1, 1);
    step("train2", 1'b0, 32'h100, 1'b1, 1'b1, 32'h140,
         mk(1'b1, 3'b000, 32'h100, 32'd5, 32'd5, 32'h40, 1'b0, 32'h0), 1'b1, 32'h140, 2, 2);
    step("blt_signed", 1'b0, 32'h100, 1'b1, 1'b1, 32'h140,
         mk(1'b1, 3'b100, 32'h208, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0, 32'h0), 1'b1, 32'h228, 3, 3);
    step("bltu_unsigned", 1'b0, 32'h208, 1'b1, 1'b1, 32'h228,
         mk(1'b1, 3'b110, 32'h20C, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0, 32'h0), 1'b0, 32'h0, 4, 3);
    step("bne_wrong_tgt", 1'b0, 32'h20C, 1'b1, 1'b0, 32'h210,
         mk(1'b1, 3'b001, 32'h304, 32'd1, 32'd2, 32'h10, 1'b1, 32'h999), 1'b1, 32'h314, 5, 4);
    step("bne_right_tgt", 1'b0, 32'h304, 1'b1, 1'b1, 32'h314,
         mk(1'b1, 3'b001, 32'h304, 32'd1, 32'd2, 32'h10, 1'b1, 32'h314), 1'b0, 32'h0, 6, 4);
    for (int i = 0; i < 5; i++)
      step("sat_taken", 1'b0, 32'h110, 1'b1, (i != 0), (i != 0) ? 32'h150 : 32'h114,
           mk(1'b1, 3'b000, 32'h110, 32'd0, 32'd0, 32'h40, 1'b1, 32'h150), 1'b0, 32'h0, 7 + i, 4);
    step("sat_not_taken", 1'b0, 32'h110, 1'b1, 1'b1, 32'h150,
         mk(1'b1, 3'b001, 32'h110, 32'd0, 32'd0, 32'h40, 1'b1, 32'h150), 1'b1, 32'h114, 12, 5);
    step("alias_resolve", 1'b0, 32'h110, 1'b1, 1'b1, 32'h150,
         mk(1'b1, 3'b000, 32'h150, 32'd3, 32'd3, 32'h40, 1'b0, 32'h0), 1'b1, 32'h190, 13, 6);
    step("alias_back", 1'b0, 32'h150, 1'b1, 1'b1, 32'h190,
         mk(1'b1, 3'b000, 32'h110, 32'd3, 32'd3, 32'h40, 1'b0, 32'h0), 1'b1, 32'h150, 14, 7);
    step("reinit_nt", 1'b0, 32'h110, 1'b1, 1'b1, 32'h150,
         mk(1'b1, 3'b001, 32'h110, 32'd3, 32'd3, 32'h40, 1'b0, 32'h0), 1'b0, 32'h0, 15, 7);
    step("funct3_010", 1'b0, 32'h110, 1'b1, 1'b0, 32'h114,
         mk(1'b1, 3'b010, 32'h110, 32'd3, 32'd3, 32'h40, 1'b0, 32'h0), 1'b0, 32'h0, 15, 7);
    step("funct3_011", 1'b0, 32'h110, 1'b1, 1'b0, 32'h114,
         mk(1'b1, 3'b011, 32'h110, 32'd0, 32'd1, 32'h40, 1'b1, 32'h0), 1'b0, 32'h0, 15, 7);
    step("rst_midstream", 1'b1, 32'h110, 1'b1, 1'b0, 32'h114,
         mk(1'b1, 3'b000, 32'h104, 32'd7, 32'd7, 32'h80, 1'b0, 32'h0), 1'b0, 32'h0, 0, 0);
    step("post_rst_a", 1'b0, 32'h304, 1'b1, 1'b0, 32'h308, none, 1'b0, 32'h0, 0, 0);
    step("post_rst_b", 1'b0, 32'h100, 1'b1, 1'b0, 32'h104, none, 1'b0, 32'h0, 0, 0);
    step("pc_wrap", 1'b0, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0, none, 1'b0, 32'h0, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
